// File: rtl/timer_pkg.sv
// Shared constants and the digit-to-segment encoder for the HH:MM:SS display.
// Segment patterns are active-low in {dp,g,f,e,d,c,b,a} order with dp off.
package timer_pkg;

    localparam logic [7:0] NUMBER_0 = 8'hC0;
    localparam logic [7:0] NUMBER_1 = 8'hF9;
    localparam logic [7:0] NUMBER_2 = 8'hA4;
    localparam logic [7:0] NUMBER_3 = 8'hB0;
    localparam logic [7:0] NUMBER_4 = 8'h99;
    localparam logic [7:0] NUMBER_5 = 8'h92;
    localparam logic [7:0] NUMBER_6 = 8'h82;
    localparam logic [7:0] NUMBER_7 = 8'hF8;
    localparam logic [7:0] NUMBER_8 = 8'h80;
    localparam logic [7:0] NUMBER_9 = 8'h90;

    localparam int DIGITS = 6;

    // Clearing bit 7 lights the decimal point on an active-low pattern.
    localparam logic [7:0] DP_ON_MASK = 8'h7F;

    function automatic logic [7:0] seg_of(input logic [3:0] digit);
        case (digit)
            4'd0:    return NUMBER_0;
            4'd1:    return NUMBER_1;
            4'd2:    return NUMBER_2;
            4'd3:    return NUMBER_3;
            4'd4:    return NUMBER_4;
            4'd5:    return NUMBER_5;
            4'd6:    return NUMBER_6;
            4'd7:    return NUMBER_7;
            4'd8:    return NUMBER_8;
            4'd9:    return NUMBER_9;
            default: return NUMBER_0;
        endcase
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// One BCD digit counting 0..MOD-1; carry is high in the cycle it wraps.
// clr has priority so the parent can impose irregular rules such as 23 -> 00.
module bcd_counter #(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] value,
    output logic       carry
);

    localparam logic [3:0] LAST = 4'(MOD - 1);

    assign carry = en && (value == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= carry ? 4'd0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/timer_hms.sv
// Free-running 24-hour HH:MM:SS clock driving a 6-digit multiplexed
// seven-segment display with registered, active-low segment and digit outputs.
module timer_hms
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] number,
    output logic [5:0] digit_block
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DIGITS - 1);

    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic          tick;
    logic          scan_step;

    logic [3:0] s_units, s_tens, m_units, m_tens, h_units, h_tens;
    logic       su_carry, st_carry, mu_carry, mt_carry, hu_carry;
    logic       hour_wrap;

    logic [3:0] cur_digit;
    logic [7:0] next_number;
    logic [5:0] next_block;

    assign tick      = (tick_cnt == TICK_LAST);
    assign scan_step = (scan_cnt == SCAN_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            scan_cnt <= '0;
            idx      <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            scan_cnt <= scan_step ? '0 : scan_cnt + 1'b1;
            if (scan_step) begin
                idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end
        end
    end

    bcd_counter #(.MOD(10)) u_sec_units (
        .clk(clk), .rst(rst), .en(tick), .clr(1'b0),
        .value(s_units), .carry(su_carry)
    );

    bcd_counter #(.MOD(6)) u_sec_tens (
        .clk(clk), .rst(rst), .en(su_carry), .clr(1'b0),
        .value(s_tens), .carry(st_carry)
    );

    bcd_counter #(.MOD(10)) u_min_units (
        .clk(clk), .rst(rst), .en(st_carry), .clr(1'b0),
        .value(m_units), .carry(mu_carry)
    );

    bcd_counter #(.MOD(6)) u_min_tens (
        .clk(clk), .rst(rst), .en(mu_carry), .clr(1'b0),
        .value(m_tens), .carry(mt_carry)
    );

    // Hours are not two independent decades: 23 rolls straight to 00.
    assign hour_wrap = mt_carry && (h_tens == 4'd2) && (h_units == 4'd3);

    bcd_counter #(.MOD(10)) u_hour_units (
        .clk(clk), .rst(rst), .en(mt_carry), .clr(hour_wrap),
        .value(h_units), .carry(hu_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_tens <= '0;
        end else if (hour_wrap) begin
            h_tens <= '0;
        end else if (hu_carry) begin
            h_tens <= h_tens + 4'd1;
        end
    end

    always_comb begin
        cur_digit = s_units;
        case (idx)
            3'd0:    cur_digit = s_units;
            3'd1:    cur_digit = s_tens;
            3'd2:    cur_digit = m_units;
            3'd3:    cur_digit = m_tens;
            3'd4:    cur_digit = h_units;
            3'd5:    cur_digit = h_tens;
            default: cur_digit = s_units;
        endcase
        next_number = seg_of(cur_digit);
        if ((idx == 3'd2) || (idx == 3'd4)) begin
            next_number = next_number & DP_ON_MASK;
        end
        next_block = ~(6'b000001 << idx);
    end

    // Re-registered every cycle, so a tick refreshes the digit without a scan step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            number      <= NUMBER_0;
            digit_block <= 6'b111110;
        end else begin
            number      <= next_number;
            digit_block <= next_block;
        end
    end

endmodule

// File: tb/tb_timer_hms.sv
// Bench for timer_hms: two instances (fast scan with 10-cycle and 1-cycle ticks)
// checked cycle by cycle against an arithmetic model of the displayed time.
module tb_timer_hms;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [7:0] number_a;
    logic [5:0] block_a;
    logic [7:0] number_b;
    logic [5:0] block_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_a    = 0;
    int cyc_b    = 0;

    logic [13:0] exp_q[$];
    logic [13:0] exp_b_q[$];

    localparam logic [13:0] RST_EXP = {6'b111110, 8'hC0};

    timer_hms #(.TICK_DIV(10), .SCAN_DIV(2)) dut_a (
        .clk(clk), .rst(rst_a), .number(number_a), .digit_block(block_a)
    );

    timer_hms #(.TICK_DIV(1), .SCAN_DIV(2)) dut_b (
        .clk(clk), .rst(rst_b), .number(number_b), .digit_block(block_b)
    );

    // Clock and reset defaults
    initial begin
        clk   = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_lut(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Outputs seen after edge cyc reflect the state reached after edge cyc-1.
    function automatic logic [13:0] model(input int cyc, input int tick_div, input int scan_div);
        int m;
        int idx;
        int t;
        int d[6];
        logic [7:0] n;
        logic [5:0] blk;
        m    = cyc - 1;
        idx  = (m / scan_div) % 6;
        t    = (m / tick_div) % 86400;
        d[0] = t % 10;
        d[1] = (t / 10) % 6;
        d[2] = (t / 60) % 10;
        d[3] = (t / 600) % 6;
        d[4] = (t / 3600) % 10;
        d[5] = t / 36000;
        n = seg_lut(d[idx]);
        if (idx == 2 || idx == 4) n[7] = 1'b0;
        blk = ~(6'b000001 << idx);
        return {blk, n};
    endfunction

    task automatic pop_cmp_a(input string tag);
        logic [13:0] e;
        e = exp_q.pop_front();
        check({tag, "_blk"}, {2'b00, block_a}, {2'b00, e[13:8]});
        check({tag, "_num"}, number_a, e[7:0]);
    endtask

    task automatic pop_cmp_b(input string tag);
        logic [13:0] e;
        e = exp_b_q.pop_front();
        check({tag, "_blk"}, {2'b00, block_b}, {2'b00, e[13:8]});
        check({tag, "_num"}, number_b, e[7:0]);
    endtask

    task automatic run_a(input int ncyc, input string tag);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            cyc_a++;
            exp_q.push_back(model(cyc_a, 10, 2));
            @(negedge clk);
            pop_cmp_a(tag);
        end
    endtask

    task automatic async_reset_a(input string tag);
        #2;
        rst_a = 1'b0;
        #1;
        exp_q.push_back(RST_EXP);
        pop_cmp_a(tag);
        @(negedge clk);
        exp_q.push_back(RST_EXP);
        pop_cmp_a({tag, "_hold"});
        rst_a = 1'b1;
        cyc_a = 0;
    endtask

    task automatic seq_a();
        #3;
        rst_a = 1'b0;
        #1;
        exp_q.push_back(RST_EXP);
        pop_cmp_a("a_rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_q.push_back(RST_EXP);
            pop_cmp_a("a_rst_hold");
        end
        rst_a = 1'b1;
        cyc_a = 0;
        run_a(620, "a_run_minute");
        async_reset_a("a_rst_mid");
        run_a(375, "a_run_37s");
        async_reset_a("a_rst_37s");
        run_a(30, "a_restart");
    endtask

    task automatic seq_b();
        #3;
        rst_b = 1'b0;
        #1;
        exp_b_q.push_back(RST_EXP);
        pop_cmp_b("b_rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_b_q.push_back(RST_EXP);
            pop_cmp_b("b_rst_hold");
        end
        rst_b = 1'b1;
        cyc_b = 0;
        for (int i = 0; i < 86420; i++) begin
            @(posedge clk);
            cyc_b++;
            if (cyc_b <= 12 || cyc_b >= 86388) begin
                exp_b_q.push_back(model(cyc_b, 1, 2));
                @(negedge clk);
                pop_cmp_b(cyc_b <= 12 ? "b_start" : "b_day_wrap");
            end
        end
    endtask

    initial begin
        fork
            seq_a();
            seq_b();
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_hms.md
Name:
timer_hms

Overview:
- Free-running 24-hour clock (HH:MM:SS) driving a 6-digit multiplexed seven-segment display.
- Prescaler produces a 1 Hz tick; a scan prescaler rotates one active digit at a time.
- Sits at the board top level; outputs go straight to segment and digit-select pins.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per 1-second tick (must be >= 1).
- SCAN_DIV, 50_000, clk cycles per digit-scan step (must be >= 1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- number  output  8  segment pattern of the active digit, active-low, bit order {dp,g,f,e,d,c,b,a}.
- digit_block  output  6  digit select, one-hot active-low; bit 0 = rightmost digit (seconds units), bit 5 = hours tens.

Behaviour:
- One clock; reset asynchronous, active-low (rst=0 forces reset immediately, released synchronously to clk edges).
- Reset values:
  - sec, min and hour counters = 0; tick and scan prescalers = 0; scan index = 0.
  - digit_block = 6'b111110; number = NUMBER_0 pattern with dp off (8'b1100_0000).
- Tick prescaler:
  - counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and asserts an internal 1-cycle tick.
- Time counters, advanced on tick, as BCD digits per unit:
  - seconds 00..59; at 59 wraps to 00 and carries into minutes.
  - minutes 00..59; at 59 with carry, wraps to 00 and carries into hours.
  - hours 00..23; 23:59:59 + tick -> 00:00:00.
- Scan prescaler:
  - counts 0..SCAN_DIV-1; at wrap the scan index advances 0->1->...->5->0.
- Outputs are registered and update together in the cycle after the scan index changes:
  - digit_block = ~(6'b1 << idx).
  - number = encoding of digit idx.
- Digit map: idx0 sec units, idx1 sec tens, idx2 min units, idx3 min tens, idx4 hour units, idx5 hour tens.
- Decimal point:
  - dp lit (bit7 = 0) on idx2 and idx4 as HH.MM.SS separators.
  - dp off (bit7 = 1) on all other digits.
- number also refreshes when the displayed value changes on a tick, without waiting for a scan step; one-cycle latency from the counter update.
- Simultaneous tick and scan step:
  - both take effect in the same cycle;
  - the newly selected digit shows the post-tick value one cycle later.
- Reset mid-count discards all progress; no partial-tick carry survives reset.
- Exactly one digit_block bit is low at all times after reset.

Decomposition:
- Package timer_pkg:
  - NUMBER_0..NUMBER_9 segment constants (active-low, dp bit = 1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
  - DIGITS = 6 constant.
  - bin-to-segment function seg_of(digit 0..9); any other value maps to NUMBER_0.
- One natural sub-module: bcd_counter (parameterised modulus, enable in, carry out), instantiated for each time unit.
  - Hours use a combined 0..23 rule in the parent.

Test Plan:
- Reset: rst low for 3 cycles with TICK_DIV=10, SCAN_DIV=2 -> digit_block=111110 and number=C0 immediately, held throughout reset.
- Scan rotation (SCAN_DIV=2): release reset -> digit_block steps 111110, 111101, 111011, 110111, 101111, 011111, 111110, changing every 2 cycles.
- Seconds count (TICK_DIV=10): after 10 ticks (100 cycles) -> idx0 shows C0 and idx1 shows F9 (time 00:00:10).
- dp check (TICK_DIV=10): at reset time -> idx2 shows 0x40 (the 0 pattern with dp lit); idx0 shows C0.
- Minute carry: run 60 ticks -> 00:01:00; idx2 shows 0x79 (1 with dp); seconds digits show C0.
- Day wrap: run 86400 ticks (TICK_DIV=1) -> all digits return to 0; idx5 shows C0 and idx4 shows 0x40.
- Async reset mid-count at 00:00:37 -> outputs return to reset values without a clk edge; count restarts from 0.
